// File: rtl/signed_frame_rx.sv
// signed_frame_rx: receives a fixed-length frame of flagged signed samples
// and reports the signed sum, minimum, maximum and sum overflow, together
// with a one-cycle done pulse. A rising edge on str opens (or restarts) a frame.
//
// Optional build macro SIGNED_FRAME_RX_SAT_EN:
//   defined   -> sum_out is the exact sum clamped to the SUM_W signed range
//   undefined -> sum_out is the low SUM_W bits of the exact sum (wrap)
// ovf flags an out-of-range sum in both builds.
module signed_frame_rx #(
  parameter int DIN_W     = 4,
  parameter int SUM_W     = 8,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             str,
  input  logic [DIN_W-1:0] din,
  input  logic             din_flag,
  output logic [SUM_W-1:0] sum_out,
  output logic [DIN_W-1:0] min_out,
  output logic [DIN_W-1:0] max_out,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  // Exact accumulator: FRAME_LEN samples of DIN_W bits cannot wrap in ACC_W.
  localparam int ACC_W = DIN_W + $clog2(FRAME_LEN) + 1;
  localparam int CNT_W = $clog2(FRAME_LEN) + 1;
  // Sum and limits are compared in a width that holds both ACC_W and SUM_W.
  localparam int EXT_W = ACC_W + SUM_W;

  localparam logic signed [DIN_W-1:0] DIN_POS = {1'b0, {(DIN_W-1){1'b1}}};
  localparam logic signed [DIN_W-1:0] DIN_NEG = {1'b1, {(DIN_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] SUM_HI  = {{(ACC_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SUM_LO  = {{(ACC_W+1){1'b1}}, {(SUM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic                     str_q_r;
  logic                     start_s;
  logic signed [ACC_W-1:0]  acc_r, acc_s;
  logic        [CNT_W-1:0]  cnt_r, cnt_s;
  logic signed [DIN_W-1:0]  min_r, min_s;
  logic signed [DIN_W-1:0]  max_r, max_s;
  logic                     finish_s;
  logic signed [DIN_W-1:0]  din_sgn_s;
  logic signed [ACC_W-1:0]  din_ext_s;
  logic signed [EXT_W-1:0]  acc_ext_s;
  logic                     ovf_hi_s, ovf_lo_s, ovf_s;
  logic        [SUM_W-1:0]  sum_map_s;

  assign start_s   = str & ~str_q_r;
  assign din_sgn_s = din;
  assign din_ext_s = {{(ACC_W-DIN_W){din[DIN_W-1]}}, din};

  // Next-state and frame datapath; clears on any start edge, collects flagged samples.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    min_s    = min_r;
    max_s    = max_r;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = COLLECT;
          acc_s   = '0;
          cnt_s   = '0;
          min_s   = DIN_POS;
          max_s   = DIN_NEG;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if (start_s) begin
          // Abort and restart; the sample in this cycle is discarded.
          state_s = COLLECT;
          acc_s   = '0;
          cnt_s   = '0;
          min_s   = DIN_POS;
          max_s   = DIN_NEG;
        end else if (din_flag) begin
          acc_s = acc_r + din_ext_s;
          cnt_s = cnt_r + CNT_W'(1);
          if (din_sgn_s < min_r) begin
            min_s = din_sgn_s;
          end else begin
            min_s = min_r;
          end
          if (din_sgn_s > max_r) begin
            max_s = din_sgn_s;
          end else begin
            max_s = max_r;
          end
          if (cnt_r == CNT_LAST) begin
            state_s  = DONE;
            finish_s = 1'b1;
          end else begin
            state_s = COLLECT;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      DONE: begin
        if (start_s) begin
          state_s = COLLECT;
          acc_s   = '0;
          cnt_s   = '0;
          min_s   = DIN_POS;
          max_s   = DIN_NEG;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Range check of the exact sum and mapping onto the reported sum width.
  always_comb begin
    acc_ext_s = {{SUM_W{acc_s[ACC_W-1]}}, acc_s};
    ovf_hi_s  = (acc_ext_s > SUM_HI);
    ovf_lo_s  = (acc_ext_s < SUM_LO);
    ovf_s     = ovf_hi_s | ovf_lo_s;
`ifdef SIGNED_FRAME_RX_SAT_EN
    if (ovf_hi_s) begin
      sum_map_s = SUM_HI[SUM_W-1:0];
    end else if (ovf_lo_s) begin
      sum_map_s = SUM_LO[SUM_W-1:0];
    end else begin
      sum_map_s = acc_ext_s[SUM_W-1:0];
    end
`else
    sum_map_s = acc_ext_s[SUM_W-1:0];
`endif
  end

  // State, edge detector and frame accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      str_q_r <= 1'b0;
      acc_r   <= '0;
      cnt_r   <= '0;
      min_r   <= '0;
      max_r   <= '0;
    end else begin
      state_r <= state_s;
      str_q_r <= str;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      min_r   <= min_s;
      max_r   <= max_s;
    end
  end

  // Registered outputs; results load on the edge that samples the last flagged din.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_out <= '0;
      min_out <= '0;
      max_out <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= finish_s;
      busy <= (state_s != IDLE);
      if (finish_s) begin
        sum_out <= sum_map_s;
        min_out <= min_s;
        max_out <= max_s;
        ovf     <= ovf_s;
      end else begin
        sum_out <= sum_out;
        min_out <= min_out;
        max_out <= max_out;
        ovf     <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_signed_frame_rx.sv
// Directed bench for signed_frame_rx: default instance (SUM_W=8) and a narrow
// instance (SUM_W=5) share stimulus so overflow handling is visible.
module tb_signed_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       str = 1'b0;
  logic [3:0] din = 4'h0;
  logic       din_flag = 1'b0;

  logic [7:0] sum_out;
  logic [3:0] min_out, max_out;
  logic       ovf, done, busy;
  logic [4:0] sum5;
  logic [3:0] min5, max5;
  logic       ovf5, done5, busy5;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  signed_frame_rx u_dut (
    .clk(clk), .rst(rst), .str(str), .din(din), .din_flag(din_flag),
    .sum_out(sum_out), .min_out(min_out), .max_out(max_out),
    .ovf(ovf), .done(done), .busy(busy)
  );

  signed_frame_rx #(.DIN_W(4), .SUM_W(5), .FRAME_LEN(8)) u_dut5 (
    .clk(clk), .rst(rst), .str(str), .din(din), .din_flag(din_flag),
    .sum_out(sum5), .min_out(min5), .max_out(max5),
    .ovf(ovf5), .done(done5), .busy(busy5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, observe #1 later.
  task automatic step(input logic s, input logic [3:0] d, input logic f);
    str = s; din = d; din_flag = f;
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic frame8(input logic [31:0] vals);
    logic [31:0] v;
    v = vals;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, v[31:28], 1'b1);
      v = v << 4;
    end
  endtask

  initial begin
    // 1. reset held with activity on inputs
    #2;
    step(1'b1, 4'h7, 1'b1);
    step(1'b0, 4'h8, 1'b1);
    step(1'b1, 4'h3, 1'b0);
    chk("rst_sum", sum_out, 32'h0);
    chk("rst_min", min_out, 32'h0);
    chk("rst_max", max_out, 32'h0);
    chk("rst_ovf", ovf, 32'h0);
    chk("rst_done", done, 32'h0);
    chk("rst_busy", busy, 32'h0);
    str = 1'b0;
    #2 rst = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h5, 1'b1);
    chk("post_rst_sum", sum_out, 32'h0);
    chk("post_rst_busy", busy, 32'h0);

    // 2. basic frame 3,-2,7,-8,1,0,-1,5
    step(1'b1, 4'h0, 1'b0);
    chk("start_busy", busy, 32'h1);
    done_cnt = 0;
    frame8(32'h3E78_10F5);
    chk("basic_done", done, 32'h1);
    chk("basic_sum", sum_out, 32'h05);
    chk("basic_min", min_out, 32'h8);
    chk("basic_max", max_out, 32'h7);
    chk("basic_ovf", ovf, 32'h0);
    chk("basic_sum5", sum5, 32'h05);
    chk("basic_ovf5", ovf5, 32'h0);
    step(1'b1, 4'h0, 1'b0);
    chk("basic_done_drop", done, 32'h0);
    chk("basic_busy_drop", busy, 32'h0);
    chk("basic_one_done", done_cnt, 32'd1);

    // 4a. eight 7s: 56 fits 8 bits, overflows 5 bits
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    frame8(32'h7777_7777);
    chk("pos_sum", sum_out, 32'h38);
    chk("pos_ovf", ovf, 32'h0);
    chk("pos_min", min_out, 32'h7);
    chk("pos_ovf5", ovf5, 32'h1);
`ifdef SIGNED_FRAME_RX_SAT_EN
    chk("pos_sum5", sum5, 32'h0F);
`else
    chk("pos_sum5", sum5, 32'h18);
`endif

    // 3. gapped flags with an unflagged -8 inserted
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    done_cnt = 0;
    begin
      logic [31:0] v;
      v = 32'h3E78_10F5;
      for (int i = 0; i < 8; i++) begin
        step(1'b1, v[31:28], 1'b1);
        v = v << 4;
        if (i < 7) begin
          chk("gap_no_early_done", done, 32'h0);
          step(1'b1, (i == 2) ? 4'h8 : 4'h6, 1'b0);
        end
      end
    end
    chk("gap_done", done, 32'h1);
    chk("gap_sum", sum_out, 32'h05);
    chk("gap_min", min_out, 32'h8);
    chk("gap_max", max_out, 32'h7);
    chk("gap_one_done", done_cnt, 32'd1);

    // 4b. eight -8s: -64 fits 8 bits, overflows 5 bits
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    frame8(32'h8888_8888);
    chk("neg_sum", sum_out, 32'hC0);
    chk("neg_ovf", ovf, 32'h0);
    chk("neg_max", max_out, 32'h8);
    chk("neg_ovf5", ovf5, 32'h1);
`ifdef SIGNED_FRAME_RX_SAT_EN
    chk("neg_sum5", sum5, 32'h10);
`else
    chk("neg_sum5", sum5, 32'h00);
`endif

    // 5. restart mid-frame; flagged 7 in the restart-edge cycle is dropped
    step(1'b0, 4'h0, 1'b0);
    done_cnt = 0;
    step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h7, 1'b1);
    step(1'b1, 4'h7, 1'b1);
    step(1'b1, 4'h7, 1'b1);
    step(1'b0, 4'h7, 1'b1);
    step(1'b1, 4'h7, 1'b1);
    frame8(32'h3E78_10F5);
    chk("rs_done", done, 32'h1);
    chk("rs_sum", sum_out, 32'h05);
    chk("rs_min", min_out, 32'h8);
    chk("rs_max", max_out, 32'h7);
    step(1'b1, 4'h0, 1'b0);
    chk("rs_one_done", done_cnt, 32'd1);

    // 6. asynchronous reset mid-frame
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h2, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", busy, 32'h0);
    chk("ar_done", done, 32'h0);
    chk("ar_sum", sum_out, 32'h0);
    chk("ar_min", min_out, 32'h0);
    chk("ar_max", max_out, 32'h0);
    chk("ar_ovf5", ovf5, 32'h0);
    #2 rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'h3, 1'b1);
      chk("ar_idle_busy", busy, 32'h0);
    end
    chk("ar_no_done", done_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
